// File: rtl/interval_countdown.sv
// Interval countdown: latches an interval selector, samples its length from the parameter
// block and counts it down in divider seconds. Optional TIMER_PAUSE_EN adds a pause input.
//
// state | meaning
// IDLE  | waiting for start_timer, timer_interval holds last selector
// FETCH | selector stable for one cycle, countdown sampled at its end
// COUNT | divider running, remaining decremented on each one-second tick
// DONE  | one-cycle expired pulse, then back to IDLE
module interval_countdown #(
    parameter int DIVIDER = 27000000,
    parameter int DIV_W   = 25
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_timer,
    input  logic [1:0]       interval_sel,
    input  logic [3:0]       countdown,
`ifdef TIMER_PAUSE_EN
    input  logic             pause,
`endif
    output logic [1:0]       timer_interval,
    output logic [3:0]       remaining,
    output logic             busy,
    output logic             expired,
    output logic             one_hz_enable
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        COUNT = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVIDER - 1);

    state_t             state, state_nxt;
    logic [1:0]         interval_nxt;
    logic [3:0]         remaining_nxt;
    logic [DIV_W-1:0]   divider, divider_nxt;
    logic               hold;
    logic               tick;

`ifdef TIMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign tick          = (state == COUNT) && !hold && (divider == DIV_LAST);
    assign one_hz_enable = tick;
    assign busy          = (state == FETCH) || (state == COUNT);
    assign expired       = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            timer_interval <= 2'b00;
            remaining      <= 4'd0;
            divider        <= '0;
        end else begin
            state          <= state_nxt;
            timer_interval <= interval_nxt;
            remaining      <= remaining_nxt;
            divider        <= divider_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        interval_nxt  = timer_interval;
        remaining_nxt = remaining;
        divider_nxt   = divider;

        case (state)
            IDLE: ;
            FETCH: begin
                remaining_nxt = countdown;
                divider_nxt   = '0;
                state_nxt     = (countdown == 4'd0) ? DONE : COUNT;
            end
            COUNT: begin
                if (tick) begin
                    divider_nxt = '0;
                    if (remaining <= 4'd1) begin
                        remaining_nxt = 4'd0;
                        state_nxt     = DONE;
                    end else begin
                        remaining_nxt = remaining - 4'd1;
                    end
                end else if (!hold) begin
                    divider_nxt = divider + 1'b1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // A start aborts whatever is in flight, including a coincident tick.
        if (start_timer) begin
            interval_nxt  = interval_sel;
            state_nxt     = FETCH;
            remaining_nxt = remaining;
            divider_nxt   = divider;
        end
    end

endmodule

// File: tb/tb_interval_countdown.sv
// Bench for interval_countdown: directed scenarios plus random starts/pauses/reprogramming,
// checked cycle by cycle against an arithmetic timeline model (build with TIMER_PAUSE_EN for pause).
module tb_interval_countdown;

    localparam int DIV = 4;
`ifdef TIMER_PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       start_timer;
    logic [1:0] interval_sel;
    logic [3:0] countdown;
    logic       pause;
    logic [1:0] timer_interval;
    logic [3:0] remaining;
    logic       busy;
    logic       expired;
    logic       one_hz_enable;

    logic [3:0] vals [4];

    int n_vec  = 0;
    int n_miss = 0;

    assign countdown = vals[timer_interval];

    interval_countdown #(.DIVIDER(DIV), .DIV_W(3)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_timer   (start_timer),
        .interval_sel  (interval_sel),
        .countdown     (countdown),
`ifdef TIMER_PAUSE_EN
        .pause         (pause),
`endif
        .timer_interval(timer_interval),
        .remaining     (remaining),
        .busy          (busy),
        .expired       (expired),
        .one_hz_enable (one_hz_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: time since the last start, paused cycles, and the latched length V.
    bit m_active = 1'b0;
    int m_c      = 0;
    int m_p      = 0;
    int m_v      = 0;
    int m_sel    = 0;
    int m_last   = 0;

    int cyc       = 0;
    int start_cyc = 0;
    int exp_count = 0;
    bit seen_exp, seen_hz;
    int seen_cyc;

    task automatic model_reset();
        m_active = 1'b0;
        m_c      = 0;
        m_p      = 0;
        m_sel    = 0;
        m_last   = 0;
    endtask

    // Entered at posedge+1; drives one cycle, checks mid-cycle, returns at next posedge+1.
    task automatic step(input bit st, input logic [1:0] sel, input bit pz);
        int e_rem, e_busy, e_exp, e_hz, k;
        start_timer  = st;
        interval_sel = sel;
        pause        = pz & PAUSE_ON;
        #3;
        e_rem  = m_last;
        e_busy = 0;
        e_exp  = 0;
        e_hz   = 0;
        k      = 0;
        if (m_active) begin
            if (m_c == 1) begin
                e_busy = 1;
                m_v    = int'(vals[m_sel]);
            end else begin
                k = m_c - 2 - m_p;
                if (k < m_v * DIV) begin
                    e_busy = 1;
                    e_rem  = m_v - k / DIV;
                    e_hz   = (!pause && (k % DIV == DIV - 1)) ? 1 : 0;
                end else if (k == m_v * DIV) begin
                    e_exp = 1;
                    e_rem = 0;
                end else begin
                    m_active = 1'b0;
                    e_rem    = 0;
                end
            end
        end
        check_val("timer_interval", int'(timer_interval), m_sel);
        check_val("remaining", int'(remaining), e_rem);
        check_val("busy", int'(busy), e_busy);
        check_val("expired", int'(expired), e_exp);
        check_val("one_hz_enable", int'(one_hz_enable), e_hz);
        seen_exp = expired;
        seen_hz  = one_hz_enable;
        seen_cyc = cyc;
        if (expired) exp_count++;
        if (m_active) begin
            if (m_c >= 2 && (m_c - 2 - m_p) < m_v * DIV && pause) m_p++;
            m_c++;
        end
        if (st) begin
            m_active  = 1'b1;
            m_c       = 1;
            m_p       = 0;
            m_sel     = int'(sel);
            start_cyc = cyc;
        end
        m_last = e_rem;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_wait(input int limit, input int pz_from, input int pz_len,
                            output int lat, output int n_hz, output int first_hz);
        lat      = -1;
        n_hz     = 0;
        first_hz = -1;
        for (int i = 1; i <= limit; i++) begin
            step(1'b0, 2'b00, (i >= pz_from) && (i < pz_from + pz_len));
            if (seen_hz) begin
                n_hz++;
                if (first_hz < 0) first_hz = seen_cyc - start_cyc;
            end
            if (seen_exp) begin
                lat = seen_cyc - start_cyc;
                break;
            end
        end
        if (lat < 0) check_val("expired_timeout", 0, 1);
    endtask

    initial begin
        int lat, nhz, fhz, ec;
        vals[0] = 4'd6;
        vals[1] = 4'd8;
        vals[2] = 4'd15;
        vals[3] = 4'd10;
        reset_n      = 1'b0;
        start_timer  = 1'b0;
        interval_sel = 2'b00;
        pause        = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        // start while in reset must be ignored
        start_timer  = 1'b1;
        interval_sel = 2'b11;
        @(posedge clk);
        #1;
        start_timer = 1'b0;
        reset_n     = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0);

        // async reset in the middle of COUNT
        step(1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 2'b00, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_timer_interval", int'(timer_interval), 0);
        check_val("rst_remaining", int'(remaining), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_expired", int'(expired), 0);
        check_val("rst_one_hz", int'(one_hz_enable), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ec = exp_count;
        for (int i = 0; i < 10; i++) step(1'b0, 2'b00, 1'b0);
        check_val("idle_no_expired", exp_count - ec, 0);

        // basic interval of 6 s
        step(1'b1, 2'b00, 1'b0);
        run_wait(200, 0, 0, lat, nhz, fhz);
        check_val("lat_sel00", lat, 6 * DIV + 2);
        check_val("hz_count_sel00", nhz, 6);
        check_val("hz_first_sel00", fhz, DIV + 1);
        step(1'b0, 2'b00, 1'b0);

        // zero-length interval
        vals[1] = 4'd0;
        step(1'b1, 2'b01, 1'b0);
        run_wait(20, 0, 0, lat, nhz, fhz);
        check_val("lat_zero", lat, 2);
        check_val("hz_count_zero", nhz, 0);
        check_val("rem_zero", int'(remaining), 0);
        vals[1] = 4'd8;

        // restart mid-count at remaining == 7
        ec = exp_count;
        step(1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 2'b00, 1'b0);
        check_val("rem_before_restart", int'(remaining), 7);
        step(1'b1, 2'b01, 1'b0);
        run_wait(200, 0, 0, lat, nhz, fhz);
        check_val("lat_restart", lat, 8 * DIV + 2);
        check_val("restart_single_expired", exp_count - ec, 1);

        // reprogramming during COUNT affects only the next start
        step(1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 2'b00, 1'b0);
        vals[2] = 4'd3;
        run_wait(200, 0, 0, lat, nhz, fhz);
        check_val("lat_reprog_old", lat, 15 * DIV + 2);
        step(1'b1, 2'b10, 1'b0);
        run_wait(200, 0, 0, lat, nhz, fhz);
        check_val("lat_reprog_new", lat, 3 * DIV + 2);

`ifdef TIMER_PAUSE_EN
        step(1'b1, 2'b00, 1'b0);
        run_wait(200, 4, 7, lat, nhz, fhz);
        check_val("lat_pause", lat, 6 * DIV + 2 + 7);
        check_val("hz_count_pause", nhz, 6);
`endif

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 40) == 0)
                vals[$urandom_range(0, 3)] = 4'($urandom_range(0, 12));
            step($urandom_range(0, 24) == 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/interval_countdown.md
Name: interval_countdown

Overview:
- Consumer side of the timer-parameter interface. Drives `timer_interval` to the parameter block, samples the returned 4-bit `countdown` value, and counts it down in seconds.
- Seconds come from an internal clock divider, which restarts on every start.
- Flags `expired` to the alarm FSM when the interval runs out.
- Sits between the alarm FSM (start/select) and the parameter block (value lookup).

Parameters:
- DIVIDER, 27000000, clk cycles per one-second tick; must be ≥ 2.
- DIV_W, 25, width of the divider counter; must satisfy 2^DIV_W ≥ DIVIDER.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start_timer  input  1  single-cycle pulse from the FSM; begins or restarts an interval
- interval_sel  input  2  interval requested: 00 arm delay, 01 driver delay, 10 passenger delay, 11 alarm on
- countdown  input  4  interval length in seconds, returned combinationally by the parameter block for the current `timer_interval`
- timer_interval  output  2  selector driven to the parameter block
- remaining  output  4  seconds left, for the display
- busy  output  1  high while in FETCH or COUNT
- expired  output  1  one-cycle pulse when the interval ends
- one_hz_enable  output  1  one-cycle pulse each divider second while counting (status LED)

Behaviour:
- Reset (asynchronous assert on reset_n low, synchronous release):
  - state = IDLE; timer_interval = 00; remaining = 0; divider = 0
  - busy = 0, expired = 0, one_hz_enable = 0
- States: IDLE, FETCH, COUNT, DONE (2-bit encoding).
- IDLE:
  - On start_timer: latch interval_sel into timer_interval → FETCH.
  - timer_interval holds its last value while idle.
- FETCH (exactly one cycle):
  - timer_interval is stable, so `countdown` has settled.
  - At the end of the cycle: remaining ← countdown; divider ← 0.
  - countdown == 0 → DONE; else → COUNT.
- COUNT:
  - Divider increments every cycle.
  - When divider == DIVIDER-1: one_hz_enable = 1 (combinational), divider ← 0, remaining ← remaining − 1.
  - If remaining == 1 at that tick → remaining becomes 0, → DONE.
- DONE (one cycle): expired = 1 (decoded from state) → IDLE.
- Latency:
  - start at edge N → FETCH in cycle N+1 → COUNT from N+2.
  - Nonzero value V: expired is high exactly V·DIVIDER + 2 cycles after the start cycle.
  - V = 0: expired is high in cycle N+2.
- start_timer in FETCH, COUNT or DONE: abort the current interval, latch the new interval_sel → FETCH. No expired pulse is produced for the aborted interval. Restart wins over a coincident tick.
- start_timer while reset_n is low: ignored.
- Changes to `countdown` after FETCH are ignored; reprogramming affects only the next start.
- remaining never wraps below 0; decrements occur only in COUNT.
- one_hz_enable is 0 outside COUNT.

Optional Feature:
- Macro: TIMER_PAUSE_EN.
- Defined:
  - Adds input `pause` (1 bit).
  - While pause = 1 in COUNT: divider and remaining hold, one_hz_enable = 0.
  - pause has no effect in other states.
  - start_timer still restarts while paused.
- Undefined: no `pause` port; counting is never held.

Test Plan:
1. Reset checks, DIVIDER=4, model the parameter block with fixed values (00→6, 01→8, 10→15, 11→10):
   - Assert reset_n=0 mid-COUNT → all outputs zero immediately, without waiting for a clk edge.
   - Release reset, idle 10 cycles → expired never pulses.
2. Start with interval_sel=00 at cycle 0:
   - timer_interval=00 in cycle 1; remaining=6 in cycle 2.
   - one_hz_enable pulses at cycles 5, 9, 13, …
   - expired high only in cycle 26 (6·4+2); busy low from cycle 26.
3. Return countdown=0 for selector 01, start with 01 → no one_hz_enable, expired in cycle 2, remaining=0.
4. Restart mid-count:
   - Start 11 (10 s); at remaining=7 pulse start with sel=01.
   - No expired for the first interval; remaining reloads to 8; expired 8·4+2 cycles after the restart.
5. Reprogram the model value for 10 to 3 during a COUNT of selector 10 → remaining is unaffected; the next start of 10 loads 3.
6. (TIMER_PAUSE_EN) Start 00, hold pause for 7 cycles inside COUNT → remaining frozen throughout; expired arrives 7 cycles later than in scenario 2 (cycle 33).
